gates_pipe: RTL and testbench
=============================

# gates_pipe

Parametrised, registered successor to the two-input gate block. Computes one of eight bitwise logic functions on WIDTH-bit operands under a valid/ready handshake, with a one-deep output register. An optional accumulate mode feeds the previous result back as operand A, for stream reductions such as running XOR or OR. It sits between a stimulus or producer stage and any consumer that applies backpressure.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits (≥1).
- CNT_W, 8: width of the accumulate beat counter (≥1).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A; ignored when acc_en=1.
- b  in  WIDTH  operand B.
- op  in  3  function select (encoding in Operation).
- acc_en  in  1  use the accumulator as operand A and update it.
- acc_clr  in  1  with acc_en, use 0 as operand A and restart the count.
- out_valid  out  1  y is valid.
- out_ready  in  1  consumer takes y this cycle.
- y  out  WIDTH  registered result.
- zero  out  1  registered flag: y == 0.
- ones  out  1  registered flag: y is all ones.
- cnt  out  CNT_W  accumulate beats since the last clear; saturates.

## Operation
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A (y=A), 7 NOT_A (y=~A).
- Accept condition: accept = in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and allows full throughput.
- Effective operand A:
  - acc_en=0: A = a.
  - acc_en=1, acc_clr=0: A = acc.
  - acc_en=1, acc_clr=1: A = 0.
- On accept:
  - y, zero and ones load from the new result.
  - out_valid is set.
  - If acc_en=1, acc loads the result.
- cnt update on accept:
  - acc_en=1, acc_clr=1: cnt = 1.
  - acc_en=1, acc_clr=0: cnt increments and saturates at 2^CNT_W−1.
  - acc_en=0: cnt is unchanged.
  - acc_clr with acc_en=0 has no effect.
- out_valid clears when out_ready=1 and there is no accept in the same cycle.
- Simultaneous take and accept: y is replaced and out_valid stays 1.
- While out_valid=1 and out_ready=0, y, zero, ones, acc and cnt hold stable.
- No internal state changes on a cycle with no accept. The inputs a, b, op and acc_* are don't-care then.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on y after edge N.
- Throughput is one beat per cycle while out_ready=1.
- Reset values: out_valid=0, y=0, zero=1, ones=0, acc=0, cnt=0. in_ready=1 follows from out_valid=0.
- Reset asserted mid-operation: all state clears immediately (asynchronously) and any pending y is discarded.
- Deassertion is synchronous to clk; the first accept can occur on the first edge after rst_n rises.
- WIDTH=1 must work: zero and ones are complementary.
- The cnt wrap is forbidden. Once cnt reaches its maximum, further accumulate beats hold it there.

## Structure
- Package gates_pkg:
  - localparams OP_AND…OP_NOT_A (3-bit);
  - a function returning the result for (op, A, B) at any WIDTH.
- Sub-module gates_core: purely combinational, parametrised WIDTH, mapping op/A/B to the result. Instantiated once.
- gates_pipe holds the handshake, output register, accumulator and counter.

## Test plan
All scenarios use WIDTH=8, CNT_W=8.
- Reset: hold rst_n=0 → out_valid=0, y=0x00, zero=1, ones=0, cnt=0, in_ready=1.
- Truth table: a=0xF0, b=0xCC, op 0..7 back-to-back with out_ready=1 → y = 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0xF0, 0x0F on consecutive cycles, each one cycle after its accept.
- Backpressure:
  - out_ready=0, offer AND 0xFF/0x0F then OR 0x00/0x11.
  - Expect the first beat captured, y=0x0F, in_ready=0, and the second beat held.
  - Raise out_ready → next cycle y=0x11.
- Accumulate XOR:
  - Beat 1: acc_en=1, acc_clr=1, b=0x01.
  - Then acc_clr=0 with b=0x02, then b=0x04.
  - Expect y=0x01, 0x03, 0x07 and cnt=1, 2, 3.
  - A following beat with acc_en=0, a=0x80, b=0x00, OR → y=0x80, cnt=3.
- Flags and saturation:
  - AND 0xAA/0x55 → zero=1. NAND 0xAA/0x55 → y=0xFF, ones=1.
  - 300 accumulate beats → cnt stays at 255.
- Mid-stream reset: assert rst_n while out_valid=1 and out_ready=0 → out_valid=0, y=0, cnt=0 within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/gates_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gates_pkg
//  Purpose  : Shared definitions for the gates_pipe block. Holds the op-code
//             encoding and the single-bit gate function. Operands of any
//             width are handled by applying this function to each bit, so
//             one definition serves every WIDTH.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package gates_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NAND   = 3'd3;
    localparam logic [2:0] OP_NOR    = 3'd4;
    localparam logic [2:0] OP_XNOR   = 3'd5;
    localparam logic [2:0] OP_PASS_A = 3'd6;
    localparam logic [2:0] OP_NOT_A  = 3'd7;

    // Result of the selected function for one bit position. Every op is
    // purely bitwise, so a WIDTH-bit result is this applied per bit.
    function automatic logic gate_bit(
        input logic [2:0] op,
        input logic       a,
        input logic       b
    );
        logic r;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            OP_PASS_A: r = a;
            default:   r = ~a;          // OP_NOT_A
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gates_core.sv
`default_nettype none
// ============================================================================
//  Module   : gates_core
//  Purpose  : Combinational bitwise function unit: y = f(op, a, b).
//  Ports    : op [2:0]       function select
//             a  [WIDTH-1:0] operand A
//             b  [WIDTH-1:0] operand B
//             y  [WIDTH-1:0] result
//  Revision : 1.0 - initial release
// ============================================================================
module gates_core
    import gates_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign y[i] = gate_bit(op, a[i], b[i]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/gates_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : gates_pipe
//  Purpose  : Registered bitwise gate stage with valid/ready handshake, a
//             one-deep output register, and an optional accumulate mode in
//             which the previous accumulated result replaces operand A.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset
//             in_valid   input beat offered
//             in_ready   beat can be accepted this cycle
//             a, b       operands (a ignored when acc_en=1)
//             op [2:0]   function select
//             acc_en     use/update the accumulator as operand A
//             acc_clr    with acc_en: operand A = 0 and restart cnt
//             out_valid  y holds an untaken result
//             out_ready  consumer takes y this cycle
//             y          registered result
//             zero, ones registered flags for y == 0 / y == all ones
//             cnt        accumulate beats since last clear (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module gates_pipe
    import gates_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] cnt
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_ones;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_result;

    // The output register frees up in the same cycle it is taken, giving
    // full throughput with a single stage of storage.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_op_a = a;
        if (acc_en) begin
            w_op_a = acc_clr ? '0 : r_acc;
        end
    end

    gates_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (op),
        .a  (w_op_a),
        .b  (b),
        .y  (w_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b1;
            r_ones      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_y         <= w_result;
            r_zero      <= ~|w_result;
            r_ones      <= &w_result;
            if (acc_en) begin
                r_acc <= w_result;
                if (acc_clr) begin
                    r_cnt <= CNT_W'(1);
                end else if (r_cnt != {CNT_W{1'b1}}) begin
                    // Saturate rather than wrap back to zero.
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero      = r_zero;
    assign ones      = r_ones;
    assign cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gates_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gates_pipe
//  Purpose  : Self-checking bench for gates_pipe (WIDTH=8, CNT_W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gates_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_en;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic       ones;
    logic [7:0] cnt;

    int checks = 0;
    int errors = 0;
    bit model_on = 0;

    gates_pipe #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ones      (ones),
        .cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] model_fn(input logic [2:0] f, input logic [7:0] x, input logic [7:0] z);
        case (f)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return 8'hFF - (x & z);
            3'd4: return 8'hFF - (x | z);
            3'd5: return 8'hFF - (x ^ z);
            3'd6: return x;
            default: return 8'hFF - x;
        endcase
    endfunction

    bit         m_valid;
    logic [7:0] m_y;
    logic [7:0] m_acc;
    int         m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0;
            m_y     = 8'h00;
            m_acc   = 8'h00;
            m_cnt   = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            logic [7:0] opa;
            logic [7:0] r;
            opa = acc_en ? (acc_clr ? 8'h00 : m_acc) : a;
            r = model_fn(op, opa, b);
            m_y = r;
            m_valid = 1;
            if (acc_en) begin
                m_acc = r;
                m_cnt = acc_clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    // Compare process: every falling edge once the model is in step.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_out_valid", int'(out_valid), int'(m_valid));
            chk("m_in_ready", int'(in_ready), int'(!m_valid || out_ready));
            chk("m_cnt", int'(cnt), m_cnt);
            chk("m_y", int'(y), int'(m_y));
            chk("m_zero", int'(zero), int'(m_y == 8'h00));
            chk("m_ones", int'(ones), int'(m_y == 8'hFF));
        end
    end

    // Inputs change 2 time units after a rising edge; literal checks sit at
    // rising edge + 1.
    task automatic edge_chk;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tt_exp [8];

    initial begin
        tt_exp[0] = 8'hC0; tt_exp[1] = 8'hFC; tt_exp[2] = 8'h3C; tt_exp[3] = 8'h3F;
        tt_exp[4] = 8'h03; tt_exp[5] = 8'hC3; tt_exp[6] = 8'hF0; tt_exp[7] = 8'h0F;

        rst_n = 0; in_valid = 0; a = 0; b = 0; op = 0;
        acc_en = 0; acc_clr = 0; out_ready = 0;
        #23;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_ones", int'(ones), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1;
        model_on = 1;
        @(posedge clk); #2;

        // Truth table, back to back.
        out_ready = 1; in_valid = 1; a = 8'hF0; b = 8'hCC;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            edge_chk();
            chk($sformatf("tt_op%0d", k), int'(y), int'(tt_exp[k]));
            chk("tt_valid", int'(out_valid), 1);
            #1;
        end

        // Drain, then backpressure.
        in_valid = 0;
        edge_chk(); #1;
        out_ready = 0; in_valid = 1; op = 3'd0; a = 8'hFF; b = 8'h0F;
        edge_chk();
        chk("bp_first_y", int'(y), 8'h0F);
        chk("bp_in_ready", int'(in_ready), 0);
        #1;
        op = 3'd1; a = 8'h00; b = 8'h11;
        edge_chk();
        chk("bp_held_y", int'(y), 8'h0F);
        #1;
        out_ready = 1;
        edge_chk();
        chk("bp_release_y", int'(y), 8'h11);
        #1;

        // Accumulate XOR.
        acc_en = 1; acc_clr = 1; op = 3'd2; a = 8'h5A; b = 8'h01;
        edge_chk();
        chk("acc1_y", int'(y), 8'h01); chk("acc1_cnt", int'(cnt), 1);
        #1;
        acc_clr = 0; b = 8'h02;
        edge_chk();
        chk("acc2_y", int'(y), 8'h03); chk("acc2_cnt", int'(cnt), 2);
        #1;
        b = 8'h04;
        edge_chk();
        chk("acc3_y", int'(y), 8'h07); chk("acc3_cnt", int'(cnt), 3);
        #1;
        acc_en = 0; op = 3'd1; a = 8'h80; b = 8'h00;
        edge_chk();
        chk("noacc_y", int'(y), 8'h80); chk("noacc_cnt", int'(cnt), 3);
        #1;

        // Flags.
        op = 3'd0; a = 8'hAA; b = 8'h55;
        edge_chk();
        chk("and_zero", int'(zero), 1); chk("and_ones", int'(ones), 0);
        #1;
        op = 3'd3;
        edge_chk();
        chk("nand_y", int'(y), 8'hFF); chk("nand_ones", int'(ones), 1);
        chk("nand_zero", int'(zero), 0);
        #1;

        // Saturation with intermittent backpressure.
        acc_en = 1; acc_clr = 1; op = 3'd2; b = 8'h33;
        edge_chk(); #1;
        acc_clr = 0;
        for (int k = 0; k < 600; k++) begin
            b = 8'(k * 7);
            out_ready = (k % 3) != 0;
            edge_chk(); #1;
        end
        chk("sat_cnt", int'(cnt), 255);
        out_ready = 1;
        edge_chk(); #1;
        chk("sat_hold_cnt", int'(cnt), 255);

        // Mid-stream asynchronous reset while stalled.
        out_ready = 0; acc_en = 0; op = 3'd6; a = 8'h3C;
        edge_chk(); #1;
        in_valid = 0;
        #1;
        chk("pre_rst_valid", int'(out_valid), 1);
        rst_n = 0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_cnt", int'(cnt), 0);
        chk("arst_zero", int'(zero), 1);
        #10;
        rst_n = 1;
        @(posedge clk); #2;
        in_valid = 1; out_ready = 1; op = 3'd1; a = 8'h21; b = 8'h04;
        edge_chk();
        chk("post_rst_y", int'(y), 8'h25);
        #1;
        in_valid = 0;
        edge_chk(); #1;
        model_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
